// File: rtl/ad9958_seq_pkg.sv
// Shared constants and types for the AD995x sequencing controller.
// Holds the register addresses, frame lengths (in bytes, instruction byte
// included), the default serial I/O mode code, the FSM state enums, and a
// small helper that finds the lowest set bit of a channel mask.
package ad9958_seq_pkg;

  localparam logic [4:0] ADDR_CSR   = 5'h00;
  localparam logic [4:0] ADDR_FR1   = 5'h01;
  localparam logic [4:0] ADDR_CFR   = 5'h03;
  localparam logic [4:0] ADDR_CFTW0 = 5'h04;
  localparam logic [4:0] ADDR_ACR   = 5'h06;

  localparam logic [4:0] LEN_CSR   = 5'd2;
  localparam logic [4:0] LEN_FR1   = 5'd4;
  localparam logic [4:0] LEN_CFR   = 5'd4;
  localparam logic [4:0] LEN_CFTW0 = 5'd5;
  localparam logic [4:0] LEN_ACR   = 5'd4;

  localparam logic [1:0] IO_MODE_4BIT = 2'b11;

  typedef enum logic [3:0] {
    RST_PULSE,
    INIT_FR1,
    INIT_CSR,
    INIT_CFR,
    IO_UPD,
    IDLE,
    SNAP,
    CH_CSR,
    CH_FTW,
    CH_ACR,
    NEXT_CH,
    ACK
  } seq_state_e;

  typedef enum logic [1:0] {
    X_IDLE,
    X_ARM,
    X_WAIT_HI,
    X_WAIT_LO
  } xfer_state_e;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [1:0] lowest_set(input logic [3:0] mask);
    logic [1:0] idx;
    idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ad9958_xfer_ctrl.sv
// Trigger/busy handshake towards the AD995x SPI shift engine.
// Ports:
//   i_clock, i_reset_n      : clock, async active-low reset
//   i_start                 : one-cycle request to send a frame
//   i_addr, i_payload, i_len: register address, left-justified payload
//                             bytes, total byte count incl. instruction
//   i_busy                  : SPI engine busy
//   o_trigger               : one-cycle transfer start
//   o_data_input            : frame, instruction byte at [63:56]
//   o_packs_to_send         : byte count of the frame
//   o_done                  : one-cycle pulse once busy has risen and fallen
//
// state     | meaning
// X_IDLE    | waiting for i_start; frame latched on start
// X_ARM     | frame held, trigger raised once the engine is idle
// X_WAIT_HI | trigger issued, waiting for busy to rise
// X_WAIT_LO | engine shifting, waiting for busy to fall
module ad9958_xfer_ctrl
  import ad9958_seq_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic [4:0]  i_addr,
  input  logic [55:0] i_payload,
  input  logic [4:0]  i_len,
  input  logic        i_busy,
  output logic        o_trigger,
  output logic [63:0] o_data_input,
  output logic [4:0]  o_packs_to_send,
  output logic        o_done
);

  xfer_state_e r_state;
  logic        r_trigger;
  logic [63:0] r_data;
  logic [4:0]  r_packs;
  logic        r_done;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= X_IDLE;
      r_trigger <= 1'b0;
      r_data    <= '0;
      r_packs   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_trigger <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        X_IDLE: begin
          if (i_start) begin
            r_data  <= {3'b000, i_addr, i_payload};
            r_packs <= i_len;
            r_state <= X_ARM;
          end
        end
        X_ARM: begin
          if (!i_busy) begin
            r_trigger <= 1'b1;
            r_state   <= X_WAIT_HI;
          end
        end
        X_WAIT_HI: begin
          if (i_busy) r_state <= X_WAIT_LO;
        end
        X_WAIT_LO: begin
          if (!i_busy) begin
            r_done  <= 1'b1;
            r_state <= X_IDLE;
          end
        end
        default: r_state <= X_IDLE;
      endcase
    end
  end

  assign o_trigger       = r_trigger;
  assign o_data_input    = r_data;
  assign o_packs_to_send = r_packs;
  assign o_done          = r_done;

endmodule

// File: rtl/ad9958_seq_ctrl.sv
// AD995x programming sequencer for 1..4 channels: master reset, FR1/CSR/CFR
// initialisation, then host-driven FTW/ASF updates that only rewrite the
// channels whose values changed, closed by a single io_update.
// Ports:
//   i_clock, i_reset_n  : clock, async active-low reset
//   i_ftw, i_asf        : per-channel tuning words / amplitude scale factors
//   i_dac_fscale        : per-channel CFR[9:8]
//   i_vco_gain          : FR1[23]
//   i_clock_multiplier  : FR1[22:18]
//   i_update_req        : one-cycle update request
//   o_update_ack        : one-cycle pulse when an update completes
//   o_init_done         : high once initialisation is finished
//   i_busy, o_trigger, o_packs_to_send, o_data_input : SPI engine handshake
//   o_master_reset, o_io_update : DDS control pins
//
// state     | meaning
// RST_PULSE | master_reset high for RESET_HOLD cycles
// INIT_FR1  | write FR1
// INIT_CSR  | select channel r_ch
// INIT_CFR  | write CFR of channel r_ch
// IO_UPD    | io_update high for UPDATE_HOLD cycles
// IDLE      | waiting for a request
// SNAP      | latch ftw/asf, build changed-channel mask
// CH_CSR    | select channel r_ch
// CH_FTW    | write CFTW0 of channel r_ch
// CH_ACR    | write ACR of channel r_ch
// NEXT_CH   | pick the next changed channel or finish
// ACK       | update_ack pulse
module ad9958_seq_ctrl
  import ad9958_seq_pkg::*;
#(
  parameter int         NUM_CH      = 2,
  parameter logic [1:0] IO_MODE     = IO_MODE_4BIT,
  parameter int         RESET_HOLD  = 4,
  parameter int         UPDATE_HOLD = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic [NUM_CH*32-1:0]  i_ftw,
  input  logic [NUM_CH*10-1:0]  i_asf,
  input  logic [NUM_CH*2-1:0]   i_dac_fscale,
  input  logic                  i_vco_gain,
  input  logic [4:0]            i_clock_multiplier,
  input  logic                  i_update_req,
  output logic                  o_update_ack,
  output logic                  o_init_done,
  input  logic                  i_busy,
  output logic                  o_trigger,
  output logic [4:0]            o_packs_to_send,
  output logic [63:0]           o_data_input,
  output logic                  o_master_reset,
  output logic                  o_io_update
);

  if (NUM_CH < 1 || NUM_CH > 4) begin : g_bad_num_ch
    $error("ad9958_seq_ctrl: NUM_CH must be within 1..4");
  end
  if (RESET_HOLD < 1 || UPDATE_HOLD < 1) begin : g_bad_hold
    $error("ad9958_seq_ctrl: RESET_HOLD and UPDATE_HOLD must be >= 1");
  end

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  seq_state_e           r_state;
  logic [CH_W-1:0]      r_ch;
  logic [NUM_CH-1:0]    r_mask;
  logic [NUM_CH*32-1:0] r_ftw;
  logic [NUM_CH*10-1:0] r_asf;
  logic                 r_upd_seen;
  logic                 r_pend;
  logic                 r_init_done;
  logic                 r_ack;
  logic                 r_mr;
  logic                 r_iou;
  logic [7:0]           r_cnt;
  logic                 r_start;
  logic                 r_issued;

  logic [NUM_CH-1:0]    w_mask;
  logic                 w_xfer_state;
  logic                 w_done;
  logic [4:0]           w_addr;
  logic [4:0]           w_len;
  logic [55:0]          w_payload;
  logic [3:0]           w_chan_en;
  logic [31:0]          w_ftw;
  logic [9:0]           w_asf;
  logic [1:0]           w_fscale;

  // The very first update after (re)initialisation rewrites every channel.
  always_comb begin
    w_mask = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_mask[k] = !r_upd_seen
                  || (i_ftw[32*k +: 32] != r_ftw[32*k +: 32])
                  || (i_asf[10*k +: 10] != r_asf[10*k +: 10]);
    end
  end

  always_comb begin
    w_xfer_state = 1'b0;
    case (r_state)
      INIT_FR1, INIT_CSR, INIT_CFR, CH_CSR, CH_FTW, CH_ACR: w_xfer_state = 1'b1;
      default: w_xfer_state = 1'b0;
    endcase
  end

  assign w_chan_en = 4'b0001 << r_ch;
  assign w_ftw     = r_ftw[32*int'(r_ch) +: 32];
  assign w_asf     = r_asf[10*int'(r_ch) +: 10];
  assign w_fscale  = i_dac_fscale[2*int'(r_ch) +: 2];

  // Payload bytes are left-justified directly under the instruction byte.
  always_comb begin
    w_addr    = ADDR_CSR;
    w_len     = LEN_CSR;
    w_payload = '0;
    case (r_state)
      INIT_FR1: begin
        w_addr    = ADDR_FR1;
        w_len     = LEN_FR1;
        w_payload = {i_vco_gain, i_clock_multiplier, 18'b0, 32'b0};
      end
      INIT_CSR, CH_CSR: begin
        w_addr    = ADDR_CSR;
        w_len     = LEN_CSR;
        w_payload = {w_chan_en, 1'b0, IO_MODE, 1'b0, 48'b0};
      end
      INIT_CFR: begin
        w_addr    = ADDR_CFR;
        w_len     = LEN_CFR;
        w_payload = {14'b0, w_fscale, 8'h02, 32'b0};
      end
      CH_FTW: begin
        w_addr    = ADDR_CFTW0;
        w_len     = LEN_CFTW0;
        w_payload = {w_ftw, 24'b0};
      end
      CH_ACR: begin
        w_addr    = ADDR_ACR;
        w_len     = LEN_ACR;
        w_payload = {11'b0, 1'b1, 2'b00, w_asf, 32'b0};
      end
      default: begin
        w_addr    = ADDR_CSR;
        w_len     = LEN_CSR;
        w_payload = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= RST_PULSE;
      r_ch        <= '0;
      r_mask      <= '0;
      r_ftw       <= '0;
      r_asf       <= '0;
      r_upd_seen  <= 1'b0;
      r_pend      <= 1'b0;
      r_init_done <= 1'b0;
      r_ack       <= 1'b0;
      r_mr        <= 1'b0;
      r_iou       <= 1'b0;
      r_cnt       <= '0;
      r_start     <= 1'b0;
      r_issued    <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_ack   <= 1'b0;
      // Requests outside IDLE/ACK are parked; the consuming states clear it.
      if (i_update_req) r_pend <= 1'b1;

      // Every transfer state issues exactly one start, then waits for done.
      if (w_xfer_state && !r_issued) begin
        r_start  <= 1'b1;
        r_issued <= 1'b1;
      end
      if (w_done) r_issued <= 1'b0;

      case (r_state)
        RST_PULSE: begin
          if (!r_mr) begin
            r_mr  <= 1'b1;
            r_cnt <= 8'(RESET_HOLD - 1);
          end else if (r_cnt == '0) begin
            r_mr    <= 1'b0;
            r_state <= INIT_FR1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        INIT_FR1: begin
          if (w_done) begin
            r_ch    <= '0;
            r_state <= INIT_CSR;
          end
        end
        INIT_CSR: begin
          if (w_done) r_state <= INIT_CFR;
        end
        INIT_CFR: begin
          if (w_done) begin
            if (r_ch == CH_W'(NUM_CH - 1)) begin
              r_state <= IO_UPD;
            end else begin
              r_ch    <= r_ch + 1'b1;
              r_state <= INIT_CSR;
            end
          end
        end
        IO_UPD: begin
          if (!r_iou) begin
            r_iou <= 1'b1;
            r_cnt <= 8'(UPDATE_HOLD - 1);
          end else if (r_cnt == '0) begin
            r_iou <= 1'b0;
            if (!r_init_done) begin
              r_init_done <= 1'b1;
              if (r_pend || i_update_req) begin
                r_pend  <= 1'b0;
                r_state <= SNAP;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_ack   <= 1'b1;
              r_state <= ACK;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        IDLE: begin
          if (i_update_req || r_pend) begin
            r_pend  <= 1'b0;
            r_state <= SNAP;
          end
        end
        SNAP: begin
          r_ftw      <= i_ftw;
          r_asf      <= i_asf;
          r_upd_seen <= 1'b1;
          r_mask     <= w_mask;
          if (w_mask == '0) begin
            r_ack   <= 1'b1;
            r_state <= ACK;
          end else begin
            r_state <= NEXT_CH;
          end
        end
        NEXT_CH: begin
          if (r_mask == '0) begin
            r_state <= IO_UPD;
          end else begin
            r_ch    <= CH_W'(lowest_set(4'(r_mask)));
            r_mask  <= r_mask & (r_mask - 1'b1);
            r_state <= CH_CSR;
          end
        end
        CH_CSR: begin
          if (w_done) r_state <= CH_FTW;
        end
        CH_FTW: begin
          if (w_done) r_state <= CH_ACR;
        end
        CH_ACR: begin
          if (w_done) r_state <= NEXT_CH;
        end
        ACK: begin
          if (i_update_req || r_pend) begin
            r_pend  <= 1'b0;
            r_state <= SNAP;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= RST_PULSE;
      endcase
    end
  end

  ad9958_xfer_ctrl u_xfer (
    .i_clock         (i_clock),
    .i_reset_n       (i_reset_n),
    .i_start         (r_start),
    .i_addr          (w_addr),
    .i_payload       (w_payload),
    .i_len           (w_len),
    .i_busy          (i_busy),
    .o_trigger       (o_trigger),
    .o_data_input    (o_data_input),
    .o_packs_to_send (o_packs_to_send),
    .o_done          (w_done)
  );

  assign o_update_ack   = r_ack;
  assign o_init_done    = r_init_done;
  assign o_master_reset = r_mr;
  assign o_io_update    = r_iou;

endmodule

// File: tb/tb_ad9958_seq_ctrl.sv
module tb_ad9958_seq_ctrl;

  localparam int NUM_CH      = 2;
  localparam int RESET_HOLD  = 4;
  localparam int UPDATE_HOLD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] ftw;
  logic [19:0] asf;
  logic [3:0]  fscale;
  logic        vco;
  logic [4:0]  cm;
  logic        req = 1'b0;
  logic        busy = 1'b0;
  logic        ack, init_done, trig, mr, iou;
  logic [4:0]  packs;
  logic [63:0] data;

  always #5 clk = ~clk;

  ad9958_seq_ctrl #(
    .NUM_CH      (NUM_CH),
    .RESET_HOLD  (RESET_HOLD),
    .UPDATE_HOLD (UPDATE_HOLD)
  ) dut (
    .i_clock            (clk),
    .i_reset_n          (rst_n),
    .i_ftw              (ftw),
    .i_asf              (asf),
    .i_dac_fscale       (fscale),
    .i_vco_gain         (vco),
    .i_clock_multiplier (cm),
    .i_update_req       (req),
    .o_update_ack       (ack),
    .o_init_done        (init_done),
    .i_busy             (busy),
    .o_trigger          (trig),
    .o_packs_to_send    (packs),
    .o_data_input       (data),
    .o_master_reset     (mr),
    .o_io_update        (iou)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int req_cyc = 0;
  int ack_cyc = 0;
  int n_ack = 0;
  int mr_run = 0;
  int iou_run = 0;

  // kind: 0 frame, 1 io_update pulse, 2 ack, 3 master_reset pulse
  typedef struct {
    int          kind;
    logic [63:0] d;
    int          n;
  } ev_t;

  ev_t got_q[$];
  ev_t exp_q[$];

  logic [31:0] m_ftw [4];
  logic [9:0]  m_asf [4];
  bit          m_first;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SPI engine stand-in: busy rises 3 cycles after trigger, stays 8 cycles.
  initial forever begin
    @(negedge clk);
    if (trig) begin
      repeat (3) @(negedge clk);
      busy = 1'b1;
      repeat (8) @(negedge clk);
      busy = 1'b0;
    end
  end

  // Event logger and per-cycle invariants.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check_val("pin_exclusive", {62'b0, mr & iou, trig & iou}, 64'd0);
      if (trig) begin
        check_val("trig_while_busy", {63'b0, busy}, 64'd0);
        got_q.push_back('{kind: 0, d: data, n: int'(packs)});
      end
      if (mr) mr_run++;
      else if (mr_run > 0) begin
        got_q.push_back('{kind: 3, d: 64'd0, n: mr_run});
        mr_run = 0;
      end
      if (iou) iou_run++;
      else if (iou_run > 0) begin
        got_q.push_back('{kind: 1, d: 64'd0, n: iou_run});
        iou_run = 0;
      end
      if (ack) begin
        got_q.push_back('{kind: 2, d: 64'd0, n: 0});
        n_ack++;
        ack_cyc = cyc;
      end
    end
  end

  task automatic push_frame(input int addr, input logic [63:0] p, input int n);
    logic [63:0] d;
    d = (64'(addr) << 56) | (p << (8 * (8 - n)));
    exp_q.push_back('{kind: 0, d: d, n: n});
  endtask

  task automatic model_init();
    exp_q.push_back('{kind: 3, d: 64'd0, n: RESET_HOLD});
    push_frame(1, (64'(vco) << 23) | (64'(cm) << 18), 4);
    for (int k = 0; k < NUM_CH; k++) begin
      push_frame(0, 64'((16 << k) | 6), 2);
      push_frame(3, (64'(fscale[2*k +: 2]) << 8) | 64'h2, 4);
    end
    exp_q.push_back('{kind: 1, d: 64'd0, n: UPDATE_HOLD});
    m_first = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_ftw[k] = '0;
      m_asf[k] = '0;
    end
  endtask

  task automatic model_update();
    bit any;
    any = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      logic [31:0] f;
      logic [9:0]  a;
      f = ftw[32*k +: 32];
      a = asf[10*k +: 10];
      if (m_first || f != m_ftw[k] || a != m_asf[k]) begin
        push_frame(0, 64'((16 << k) | 6), 2);
        push_frame(4, 64'(f), 5);
        push_frame(6, 64'h1000 | 64'(a), 4);
        any = 1'b1;
      end
      m_ftw[k] = f;
      m_asf[k] = a;
    end
    m_first = 1'b0;
    if (any) exp_q.push_back('{kind: 1, d: 64'd0, n: UPDATE_HOLD});
    exp_q.push_back('{kind: 2, d: 64'd0, n: 0});
  endtask

  task automatic compare_logs(input string tag);
    check_val({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check_val($sformatf("%s_kind%0d", tag, i), 64'(got_q[i].kind), 64'(exp_q[i].kind));
      check_val($sformatf("%s_data%0d", tag, i), got_q[i].d, exp_q[i].d);
      check_val($sformatf("%s_len%0d", tag, i), 64'(got_q[i].n), 64'(exp_q[i].n));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_req();
    @(negedge clk);
    req = 1'b1;
    req_cyc = cyc;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_acks(input int target, input int budget);
    int b;
    b = 0;
    while (n_ack < target && b < budget) begin
      @(negedge clk);
      b++;
    end
    check_val("ack_timeout", {63'b0, n_ack >= target}, 64'd1);
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_init(input int budget);
    int b;
    b = 0;
    while (!init_done && b < budget) begin
      @(negedge clk);
      b++;
    end
    repeat (4) @(negedge clk);
    check_val("init_done", {63'b0, init_done}, 64'd1);
  endtask

  task automatic do_update(input string tag);
    int target;
    target = n_ack + 1;
    pulse_req();
    model_update();
    wait_acks(target, 1000);
    compare_logs(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_trig"}, {63'b0, trig}, 64'd0);
    check_val({tag, "_packs"}, 64'(packs), 64'd0);
    check_val({tag, "_data"}, data, 64'd0);
    check_val({tag, "_mr"}, {63'b0, mr}, 64'd0);
    check_val({tag, "_iou"}, {63'b0, iou}, 64'd0);
    check_val({tag, "_ack"}, {63'b0, ack}, 64'd0);
    check_val({tag, "_init_done"}, {63'b0, init_done}, 64'd0);
  endtask

  initial begin
    int b;
    int target;
    ftw    = {$urandom, $urandom};
    asf    = 20'($urandom);
    fscale = 4'($urandom);
    vco    = 1'($urandom);
    cm     = 5'($urandom);

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    model_init();
    rst_n = 1'b1;
    wait_init(1000);
    compare_logs("init");

    ftw[31:0] = 32'h1234_5678;
    asf[9:0]  = 10'h3FF;
    do_update("first_update");

    ftw[63:32] = ftw[63:32] ^ ($urandom | 32'h1);
    do_update("ftw1_only");

    do_update("no_change");
    check_val("nochange_ack_latency", 64'(ack_cyc - req_cyc), 64'd2);

    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        int r;
        r = $urandom_range(0, 3);
        if (r[0]) ftw[32*k +: 32] = $urandom;
        if (r[1]) asf[10*k +: 10] = 10'($urandom);
      end
      do_update($sformatf("rand%0d", it));
    end

    // Two requests during a running sequence collapse into one more sequence.
    target = n_ack + 2;
    ftw[31:0] = ftw[31:0] ^ 32'h1;
    pulse_req();
    model_update();
    repeat (2) @(negedge clk);
    asf[19:10] = asf[19:10] ^ 10'h1;
    pulse_req();
    repeat (2) @(negedge clk);
    pulse_req();
    model_update();
    wait_acks(target, 2000);
    repeat (80) @(negedge clk);
    compare_logs("pending");

    // Reset while the engine is busy on a CFTW0 frame.
    ftw[31:0] = ftw[31:0] ^ 32'h100;
    pulse_req();
    b = 0;
    while (!(trig && data[63:56] == 8'h04) && b < 500) begin
      @(negedge clk);
      b++;
    end
    check_val("cftw0_seen", {63'b0, b < 500}, 64'd1);
    b = 0;
    while (!busy && b < 50) begin
      @(negedge clk);
      b++;
    end
    check_val("busy_seen", {63'b0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    got_q.delete();
    exp_q.delete();
    mr_run = 0;
    iou_run = 0;
    repeat (3) @(negedge clk);
    model_init();
    rst_n = 1'b1;
    wait_init(1000);
    compare_logs("reinit");

    do_update("post_reset_update");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
